// File: rtl/y86_pkg.sv
// Shared Y86-64 constants and the W pipeline register layout.
package y86_pkg;

  localparam int DATA_W = 64;
  localparam int NREG   = 15;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    STAT_AOK = 2'd0,
    STAT_HLT = 2'd1,
    STAT_ADR = 2'd2,
    STAT_INS = 2'd3
  } stat_t;

  typedef struct packed {
    stat_t              stat;
    logic [3:0]         icode;
    logic [DATA_W-1:0]  valE;
    logic [DATA_W-1:0]  valM;
    logic [3:0]         dstE;
    logic [3:0]         dstM;
  } wreg_t;

  function automatic wreg_t bubble_w();
    wreg_t w;
    w.stat  = STAT_AOK;
    w.icode = I_NOP;
    w.valE  = '0;
    w.valM  = '0;
    w.dstE  = RNONE;
    w.dstM  = RNONE;
    return w;
  endfunction

endpackage

// File: rtl/y86_regfile.sv
// 15 x 64 architectural register file: two write ports (M beats E), two async read ports.
module y86_regfile
  import y86_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we_e,
  input  logic [3:0]        i_dst_e,
  input  logic [DATA_W-1:0] i_val_e,
  input  logic              i_we_m,
  input  logic [3:0]        i_dst_m,
  input  logic [DATA_W-1:0] i_val_m,
  input  logic [3:0]        i_src_a,
  input  logic [3:0]        i_src_b,
  output logic [DATA_W-1:0] o_rval_a,
  output logic [DATA_W-1:0] o_rval_b
);

  logic [DATA_W-1:0] r_regs [NREG];

  // M port is written last so it wins when both target the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      if (i_we_e && i_dst_e != RNONE) r_regs[i_dst_e] <= i_val_e;
      if (i_we_m && i_dst_m != RNONE) r_regs[i_dst_m] <= i_val_m;
    end
  end

  assign o_rval_a = (i_src_a == RNONE) ? '0 : r_regs[i_src_a];
  assign o_rval_b = (i_src_b == RNONE) ? '0 : r_regs[i_src_b];

endmodule

// File: rtl/writeback.sv
// Y86-64 writeback stage: W pipeline register, register-file commit gating and sticky halt status.
module writeback
  import y86_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        m_stat,
  input  logic [3:0]        m_icode,
  input  logic [DATA_W-1:0] m_valE,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [3:0]        m_dstE,
  input  logic [3:0]        m_dstM,
  input  logic              W_stall,
  input  logic              W_bubble,
  output logic [1:0]        W_stat,
  output logic [3:0]        W_icode,
  output logic [DATA_W-1:0] W_valE,
  output logic [DATA_W-1:0] W_valM,
  output logic [3:0]        W_dstE,
  output logic [3:0]        W_dstM,
  input  logic [3:0]        d_srcA,
  input  logic [3:0]        d_srcB,
  output logic [DATA_W-1:0] d_rvalA,
  output logic [DATA_W-1:0] d_rvalB,
  output logic [1:0]        prog_stat,
  output logic              halted
);

  wreg_t r_w;
  logic  r_halted;
  stat_t r_halt_code;
  wreg_t w_next;
  logic  w_wr_en;

  // A stalled W is re-presented next cycle, so commit only when it moves on.
  assign w_wr_en = (r_w.stat == STAT_AOK) && !r_halted && !W_stall;

  always_comb begin
    w_next       = bubble_w();
    if (!W_bubble) begin
      w_next.stat  = stat_t'(m_stat);
      w_next.icode = m_icode;
      w_next.valE  = m_valE;
      w_next.valM  = m_valM;
      w_next.dstE  = m_dstE;
      w_next.dstM  = m_dstM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_w         <= bubble_w();
      r_halted    <= 1'b0;
      r_halt_code <= STAT_AOK;
    end else begin
      if (!r_halted && r_w.stat != STAT_AOK) begin
        r_halted    <= 1'b1;
        r_halt_code <= r_w.stat;
      end
      if (!r_halted && !W_stall) r_w <= w_next;
    end
  end

  y86_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .i_we_e   (w_wr_en),
    .i_dst_e  (r_w.dstE),
    .i_val_e  (r_w.valE),
    .i_we_m   (w_wr_en),
    .i_dst_m  (r_w.dstM),
    .i_val_m  (r_w.valM),
    .i_src_a  (d_srcA),
    .i_src_b  (d_srcB),
    .o_rval_a (d_rvalA),
    .o_rval_b (d_rvalB)
  );

  assign W_stat    = r_w.stat;
  assign W_icode   = r_w.icode;
  assign W_valE    = r_w.valE;
  assign W_valM    = r_w.valM;
  assign W_dstE    = r_w.dstE;
  assign W_dstM    = r_w.dstM;
  assign halted    = r_halted;
  assign prog_stat = r_halted ? r_halt_code : r_w.stat;

endmodule

// File: tb/tb_writeback.sv
// Directed and randomized checks of the writeback stage against a behavioural model.
module tb_writeback;
  import y86_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  m_stat = '0;
  logic [3:0]  m_icode = 4'h1;
  logic [63:0] m_valE = '0, m_valM = '0;
  logic [3:0]  m_dstE = 4'hF, m_dstM = 4'hF;
  logic        W_stall = 1'b0, W_bubble = 1'b0;
  logic [1:0]  W_stat;
  logic [3:0]  W_icode, W_dstE, W_dstM;
  logic [63:0] W_valE, W_valM;
  logic [3:0]  d_srcA = '0, d_srcB = '0;
  logic [63:0] d_rvalA, d_rvalB;
  logic [1:0]  prog_stat;
  logic        halted;

  always #5 clk = ~clk;

  writeback dut (
    .clk(clk), .rst(rst),
    .m_stat(m_stat), .m_icode(m_icode), .m_valE(m_valE), .m_valM(m_valM),
    .m_dstE(m_dstE), .m_dstM(m_dstM),
    .W_stall(W_stall), .W_bubble(W_bubble),
    .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(d_rvalA), .d_rvalB(d_rvalB),
    .prog_stat(prog_stat), .halted(halted)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Architectural model: register array, W contents, sticky halt.
  logic [63:0] mR [16];
  logic [1:0]  mWs;
  logic [3:0]  mWi, mWdE, mWdM;
  logic [63:0] mWvE, mWvM;
  logic        mH;
  logic [1:0]  mCode;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mread(input logic [3:0] id);
    return (id == 4'hF) ? 64'h0 : mR[id];
  endfunction

  task automatic model_bubble();
    mWs = 2'd0; mWi = 4'h1; mWvE = '0; mWvM = '0; mWdE = 4'hF; mWdM = 4'hF;
  endtask

  task automatic model_edge();
    logic was_halted;
    if (rst) begin
      for (int i = 0; i < 16; i++) mR[i] = '0;
      model_bubble();
      mH = 1'b0; mCode = 2'd0;
    end else begin
      was_halted = mH;
      if (mWs == 2'd0 && !was_halted && !W_stall) begin
        if (mWdE != 4'hF) mR[mWdE] = mWvE;
        if (mWdM != 4'hF) mR[mWdM] = mWvM;
      end
      if (!was_halted && mWs != 2'd0) begin
        mH = 1'b1; mCode = mWs;
      end
      if (!was_halted && !W_stall) begin
        if (W_bubble) model_bubble();
        else begin
          mWs = m_stat; mWi = m_icode; mWvE = m_valE; mWvM = m_valM;
          mWdE = m_dstE; mWdM = m_dstM;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("W_stat", 64'(W_stat), 64'(mWs));
    chk("W_icode", 64'(W_icode), 64'(mWi));
    chk("W_valE", W_valE, mWvE);
    chk("W_valM", W_valM, mWvM);
    chk("W_dstE", 64'(W_dstE), 64'(mWdE));
    chk("W_dstM", 64'(W_dstM), 64'(mWdM));
    chk("halted", 64'(halted), 64'(mH));
    chk("prog_stat", 64'(prog_stat), 64'(mH ? mCode : mWs));
    d_srcA = 4'($urandom_range(15));
    d_srcB = 4'($urandom_range(15));
    #1;
    chk("d_rvalA", d_rvalA, mread(d_srcA));
    chk("d_rvalB", d_rvalB, mread(d_srcB));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic read_a(input logic [3:0] id, input logic [63:0] exp, input string tag);
    d_srcA = id;
    #1;
    chk(tag, d_rvalA, exp);
  endtask

  task automatic set_m(input logic [1:0] s, input logic [3:0] ic, input logic [3:0] de,
                       input logic [63:0] ve, input logic [3:0] dm, input logic [63:0] vm);
    m_stat = s; m_icode = ic; m_dstE = de; m_valE = ve; m_dstM = dm; m_valM = vm;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mR[i] = '0;
    model_bubble();
    mH = 1'b0; mCode = 2'd0;

    // Reset and full read sweep
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) read_a(4'(i), 64'h0, "reset_read");
    chk("reset_dstE", 64'(W_dstE), 64'hF);
    chk("reset_dstM", 64'(W_dstM), 64'hF);
    chk("reset_icode", 64'(W_icode), 64'h1);
    chk("reset_prog_stat", 64'(prog_stat), 64'h0);

    // Simple E write, plus R5 = 9 for the later reset-while-halted check
    set_m(2'd0, 4'h6, 4'h3, 64'h55, 4'hF, 64'h0);
    step();
    set_m(2'd0, 4'h6, 4'h5, 64'h9, 4'hF, 64'h0);
    step();
    set_m(2'd0, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
    step();
    read_a(4'h3, 64'h55, "opq_R3");
    read_a(4'h0, 64'h0, "opq_R0");
    read_a(4'h1, 64'h0, "opq_R1");
    read_a(4'h2, 64'h0, "opq_R2");
    read_a(4'h5, 64'h9, "opq_R5");

    // popq: same destination on both ports, valM wins
    set_m(2'd0, 4'hB, 4'h4, 64'h100, 4'h4, 64'hABCD);
    step();
    set_m(2'd0, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
    step();
    read_a(4'h4, 64'hABCD, "pop_R4");

    // Stall, stall+bubble, bubble
    set_m(2'd0, 4'h6, 4'h7, 64'h11, 4'hF, 64'h0);
    step();
    set_m(2'd0, 4'h3, 4'h8, 64'h22, 4'hF, 64'h0);
    W_stall = 1'b1;
    step();
    chk("stall_icode", 64'(W_icode), 64'h6);
    chk("stall_valE", W_valE, 64'h11);
    W_bubble = 1'b1;
    step();
    chk("stallbub_icode", 64'(W_icode), 64'h6);
    chk("stallbub_dstE", 64'(W_dstE), 64'h7);
    W_stall = 1'b0;
    step();
    W_bubble = 1'b0;
    chk("bubble_icode", 64'(W_icode), 64'h1);
    chk("bubble_dstE", 64'(W_dstE), 64'hF);
    chk("bubble_dstM", 64'(W_dstM), 64'hF);
    read_a(4'h7, 64'h11, "bubble_R7");
    read_a(4'h8, 64'h0, "bubble_R8");

    // Halt: HLT instruction does not write, W then freezes
    set_m(2'd1, 4'h0, 4'h2, 64'h7, 4'hF, 64'h0);
    step();
    set_m(2'd0, 4'h6, 4'h2, 64'h9, 4'hF, 64'h0);
    step();
    chk("halt_halted", 64'(halted), 64'h1);
    chk("halt_prog_stat", 64'(prog_stat), 64'h1);
    read_a(4'h2, 64'h0, "halt_R2");
    set_m(2'd0, 4'h3, 4'h2, 64'h33, 4'hF, 64'h0);
    step();
    step();
    chk("frozen_icode", 64'(W_icode), 64'h6);
    chk("frozen_valE", W_valE, 64'h9);
    chk("frozen_prog_stat", 64'(prog_stat), 64'h1);
    read_a(4'h2, 64'h0, "frozen_R2");

    // Reset while halted
    read_a(4'h5, 64'h9, "prerst_R5");
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_halted", 64'(halted), 64'h0);
    chk("rst_prog_stat", 64'(prog_stat), 64'h0);
    read_a(4'h5, 64'h0, "rst_R5");

    // Randomized traffic
    for (int k = 0; k < 500; k++) begin
      rst      = mH ? ($urandom_range(99) < 10) : ($urandom_range(99) < 1);
      m_stat   = ($urandom_range(99) < 4) ? 2'($urandom_range(3, 1)) : 2'd0;
      m_icode  = 4'($urandom_range(15));
      m_valE   = {$urandom, $urandom};
      m_valM   = {$urandom, $urandom};
      m_dstE   = ($urandom_range(99) < 25) ? 4'hF : 4'($urandom_range(14));
      m_dstM   = ($urandom_range(99) < 50) ? 4'hF : 4'($urandom_range(14));
      W_stall  = ($urandom_range(99) < 20);
      W_bubble = ($urandom_range(99) < 15);
      step();
    end
    rst = 1'b0; W_stall = 1'b0; W_bubble = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
